// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-search controller and its phase handshakes.
package rc4_pkg;

  localparam int          KEY_BITS_DEFAULT = 24;
  localparam int          MESSAGE_LENGTH   = 32;
  localparam logic [15:0] WATCHDOG_MAX     = 16'hFFFF;

  localparam int NUM_PHASES = 3;
  localparam int PH_INIT    = 0;
  localparam int PH_SHUF    = 1;
  localparam int PH_DEC     = 2;

  typedef enum logic [3:0] {
    IDLE,
    INIT_GO,
    INIT_WAIT,
    SHUF_GO,
    SHUF_WAIT,
    DEC_GO,
    DEC_WAIT,
    CHECK,
    FOUND,
    EXHAUSTED
  } ks_state_t;

  function automatic logic is_wait(input ks_state_t s);
    return (s == INIT_WAIT) || (s == SHUF_WAIT) || (s == DEC_WAIT);
  endfunction

  function automatic logic is_rest(input ks_state_t s);
    return (s == IDLE) || (s == FOUND) || (s == EXHAUSTED);
  endfunction

endpackage

// File: rtl/key_search_ctrl_phase_sequencer.sv
// One datapath phase handshake: registered one-cycle start pulse and finish qualification.
// KEY_SEARCH_WATCHDOG_EN adds a 16-bit stall watchdog with a registered timeout pulse.
module phase_sequencer (
  input  logic clk,
  input  logic reset_n,
  input  logic launch,
  input  logic in_wait,
  input  logic finish,
  output logic start,
  output logic done
`ifdef KEY_SEARCH_WATCHDOG_EN
  ,
  output logic timeout
`endif
);

  // finish only counts while the owning FSM is actually waiting on this phase
  assign done = in_wait & finish;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) start <= 1'b0;
    else          start <= launch;
  end

`ifdef KEY_SEARCH_WATCHDOG_EN
  import rc4_pkg::*;

  logic [15:0] wd_cnt;

  // start is high exactly in the GO cycle, so wd_cnt reads 0 on the first wait cycle;
  // timeout is registered one count early so it is high while wd_cnt == WATCHDOG_MAX
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      if (start)        wd_cnt <= '0;
      else if (in_wait) wd_cnt <= wd_cnt + 16'd1;
      timeout <= in_wait & ~finish & (wd_cnt == (WATCHDOG_MAX - 16'd1));
    end
  end
`endif

endmodule

// File: rtl/key_search_ctrl.sv
// Key-search controller: steps secret_key through the init/shuffle/decrypt phases until a
// decrypt passes, the key range runs out, or stop aborts. KEY_SEARCH_WATCHDOG_EN adds phase_timeout.
module key_search_ctrl
  import rc4_pkg::*;
#(
  parameter int                  KEY_BITS  = KEY_BITS_DEFAULT,
  parameter logic [KEY_BITS-1:0] KEY_FIRST = '0,
  parameter logic [KEY_BITS-1:0] KEY_STEP  = KEY_BITS'(1),
  parameter logic [KEY_BITS-1:0] KEY_LAST  = KEY_BITS'(24'h3FFFFF)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                stop,
  output logic                init_start,
  input  logic                init_finish,
  output logic                shuffle_start,
  input  logic                shuffle_finish,
  output logic                decrypt_start,
  input  logic                decrypt_finish,
  input  logic                invalid_ascii,
  output logic [KEY_BITS-1:0] secret_key,
  output logic                busy,
  output logic                key_found,
  output logic                key_exhausted,
  output logic                aborted
`ifdef KEY_SEARCH_WATCHDOG_EN
  ,
  output logic                phase_timeout
`endif
);

  ks_state_t state, state_nx;
  logic      stop_lat, inv_cap;
  logic      key_ok, stop_any, restart;
  logic [KEY_BITS:0]       key_next;
  logic [NUM_PHASES-1:0]   launch, in_wait, finish, ph_start, ph_done, ph_tmo;

  assign finish  = {decrypt_finish, shuffle_finish, init_finish};
  assign in_wait = {state == DEC_WAIT, state == SHUF_WAIT, state == INIT_WAIT};
  assign launch  = {state_nx == DEC_GO, state_nx == SHUF_GO, state_nx == INIT_GO};
  assign {decrypt_start, shuffle_start, init_start} = ph_start;

  for (genvar i = 0; i < NUM_PHASES; i++) begin : g_phase
    phase_sequencer u_seq (
      .clk     (clk),
      .reset_n (reset_n),
      .launch  (launch[i]),
      .in_wait (in_wait[i]),
      .finish  (finish[i]),
      .start   (ph_start[i]),
      .done    (ph_done[i])
`ifdef KEY_SEARCH_WATCHDOG_EN
      ,
      .timeout (ph_tmo[i])
`endif
    );
  end

`ifdef KEY_SEARCH_WATCHDOG_EN
  assign phase_timeout = |ph_tmo;
`else
  assign ph_tmo = '0;
`endif

  // one extra bit so a step past the top of the key space can never wrap back into range
  assign key_next = {1'b0, secret_key} + {1'b0, KEY_STEP};
  assign key_ok   = key_next <= {1'b0, KEY_LAST};
  assign stop_any = stop | stop_lat;
  assign restart  = is_rest(state) && (state_nx == INIT_GO);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, FOUND, EXHAUSTED: if (start && !stop) state_nx = INIT_GO;
      INIT_GO:   state_nx = stop ? IDLE : INIT_WAIT;
      INIT_WAIT: if (ph_tmo[PH_INIT])       state_nx = IDLE;
                 else if (ph_done[PH_INIT]) state_nx = stop_any ? IDLE : SHUF_GO;
      SHUF_GO:   state_nx = stop ? IDLE : SHUF_WAIT;
      SHUF_WAIT: if (ph_tmo[PH_SHUF])       state_nx = IDLE;
                 else if (ph_done[PH_SHUF]) state_nx = stop_any ? IDLE : DEC_GO;
      DEC_GO:    state_nx = stop ? IDLE : DEC_WAIT;
      // a finished decrypt always gets checked: a pending stop is resolved in CHECK, below a hit
      DEC_WAIT:  if (ph_tmo[PH_DEC])        state_nx = IDLE;
                 else if (ph_done[PH_DEC])  state_nx = CHECK;
      CHECK:     if (!inv_cap)              state_nx = FOUND;
                 else if (stop_any)         state_nx = IDLE;
                 else if (key_ok)           state_nx = INIT_GO;
                 else                       state_nx = EXHAUSTED;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      secret_key    <= KEY_FIRST;
      busy          <= 1'b0;
      key_found     <= 1'b0;
      key_exhausted <= 1'b0;
      aborted       <= 1'b0;
      stop_lat      <= 1'b0;
      inv_cap       <= 1'b0;
    end else begin
      state         <= state_nx;
      busy          <= state_nx != IDLE;
      key_found     <= state_nx == FOUND;
      key_exhausted <= state_nx == EXHAUSTED;
      if (restart) begin
        secret_key <= KEY_FIRST;
        aborted    <= 1'b0;
      end else begin
        if (state == CHECK && state_nx == INIT_GO) secret_key <= key_next[KEY_BITS-1:0];
        // every path from a running state back to IDLE is an abort of some kind
        if (state != IDLE && state_nx == IDLE) aborted <= 1'b1;
      end
      if (restart || state_nx == IDLE)  stop_lat <= 1'b0;
      else if (is_wait(state) && stop)  stop_lat <= 1'b1;
      if (ph_done[PH_DEC]) inv_cap <= invalid_ascii;
    end
  end

endmodule

// File: tb/tb_key_search_ctrl.sv
// Runs three controllers (default range, stepped 1..7, top-of-range) against behavioural datapath responders.
module tb_key_search_ctrl;

  localparam logic [23:0] KF [3] = '{24'h000000, 24'h000001, 24'hFFFFFE};
  localparam logic [23:0] KS [3] = '{24'h000001, 24'h000002, 24'h000004};
  localparam logic [23:0] KL [3] = '{24'h3FFFFF, 24'h000007, 24'hFFFFFF};
  localparam logic [24:0] NONE = 25'h1000000;

  logic clk, reset_n, start, stop;
  logic [24:0] tgt [3];
  int          lat_fix [3];
  int          checks, errors;

  logic [2:0] busy_a, found_a, exh_a, abort_a, sts_a, ins_a, sss_a, dss_a;
  logic [2:0][23:0] key_a;
  logic [2:0][31:0] ninit_a, ndec_a, ksum_a;
`ifdef KEY_SEARCH_WATCHDOG_EN
  logic [2:0] pto_a;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar d = 0; d < 3; d++) begin : g_dut
    logic init_start, init_finish, shuffle_start, shuffle_finish;
    logic decrypt_start, decrypt_finish, invalid_ascii;
    logic busy, key_found, key_exhausted, aborted;
    logic [23:0] secret_key, cur;
    logic [31:0] n_init, n_dec, ksum;
    int cnt, ph;
`ifdef KEY_SEARCH_WATCHDOG_EN
    logic phase_timeout;
    assign pto_a[d] = phase_timeout;
`endif

    key_search_ctrl #(
      .KEY_BITS(24), .KEY_FIRST(KF[d]), .KEY_STEP(KS[d]), .KEY_LAST(KL[d])
    ) u_dut (
      .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
      .init_start(init_start), .init_finish(init_finish),
      .shuffle_start(shuffle_start), .shuffle_finish(shuffle_finish),
      .decrypt_start(decrypt_start), .decrypt_finish(decrypt_finish),
      .invalid_ascii(invalid_ascii), .secret_key(secret_key),
      .busy(busy), .key_found(key_found), .key_exhausted(key_exhausted),
      .aborted(aborted)
`ifdef KEY_SEARCH_WATCHDOG_EN
      , .phase_timeout(phase_timeout)
`endif
    );

    assign busy_a[d]  = busy;
    assign found_a[d] = key_found;
    assign exh_a[d]   = key_exhausted;
    assign abort_a[d] = aborted;
    assign ins_a[d]   = init_start;
    assign sss_a[d]   = shuffle_start;
    assign dss_a[d]   = decrypt_start;
    assign sts_a[d]   = init_start | shuffle_start | decrypt_start;
    assign key_a[d]   = secret_key;
    assign ninit_a[d] = n_init;
    assign ndec_a[d]  = n_dec;
    assign ksum_a[d]  = ksum;

    // datapath model: each phase finishes after a latency; a key decrypts cleanly only if it is the target
    initial begin
      n_init = 0; n_dec = 0; ksum = 0; cnt = -1; ph = 0; cur = '0;
      init_finish = 0; shuffle_finish = 0; decrypt_finish = 0; invalid_ascii = 1;
      forever begin
        @(negedge clk);
        init_finish = 0; shuffle_finish = 0; decrypt_finish = 0;
        if (!reset_n) cnt = -1;
        else begin
          if (cnt == 0) begin
            case (ph)
              1: init_finish = 1;
              2: shuffle_finish = 1;
              default: begin
                decrypt_finish = 1;
                invalid_ascii  = ({1'b0, cur} != tgt[d]);
              end
            endcase
            cnt = -1;
          end else if (cnt > 0) cnt--;
          if (init_start) begin
            n_init++; cur = secret_key; ksum += {8'h0, secret_key}; ph = 1;
            cnt = (lat_fix[d] < 0) ? int'($urandom_range(0, 3)) : lat_fix[d];
          end
          if (shuffle_start) begin
            ph = 2; cnt = (lat_fix[d] < 0) ? int'($urandom_range(0, 3)) : lat_fix[d];
          end
          if (decrypt_start) begin
            n_dec++; ph = 3;
            cnt = (lat_fix[d] < 0) ? int'($urandom_range(0, 3)) : lat_fix[d];
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[dut%0d]: got %0h expected %0h", tag, d, obs, exp);
    end
  endtask

  task automatic bound(input string tag, input int n, input int budget);
    checks++;
    assert (n < budget) else begin
      errors++;
      $error("FAIL %s: got %0d cycles expected under %0d", tag, n, budget);
    end
  endtask

  // walk the key range by plain arithmetic: which keys get tried and where the search stops
  function automatic void model(input int d, input logic [24:0] t, output logic f,
                                output logic [23:0] k, output int tries, output logic [31:0] sum);
    logic [24:0] c;
    c = {1'b0, KF[d]}; f = 0; tries = 0; sum = 0; k = KF[d];
    for (int i = 0; i < 64; i++) begin
      tries++; sum += {8'h0, c[23:0]}; k = c[23:0];
      if (c == t) begin f = 1; break; end
      if (c + {1'b0, KS[d]} > {1'b0, KL[d]}) break;
      c = c + {1'b0, KS[d]};
    end
  endfunction

  task automatic pulse_start(input logic with_stop);
    @(negedge clk); start = 1; stop = with_stop;
    @(negedge clk); start = 0; stop = 0;
  endtask

  task automatic run_search(input string tag);
    logic [31:0] b_init [3], b_sum [3];
    logic f; logic [23:0] k; int tries; logic [31:0] sum; int n;
    for (int d = 0; d < 3; d++) begin b_init[d] = ninit_a[d]; b_sum[d] = ksum_a[d]; end
    pulse_start(1'b0);
    n = 0;
    while (((found_a | exh_a) != 3'b111) && n < 3000) begin @(negedge clk); n++; end
    bound({tag, "_done"}, n, 3000);
    for (int d = 0; d < 3; d++) begin
      model(d, tgt[d], f, k, tries, sum);
      chk({tag, "_found"}, d, {31'h0, found_a[d]}, {31'h0, f});
      chk({tag, "_exhausted"}, d, {31'h0, exh_a[d]}, {31'h0, ~f});
      chk({tag, "_key"}, d, {8'h0, key_a[d]}, {8'h0, k});
      chk({tag, "_tries"}, d, ninit_a[d] - b_init[d], tries);
      chk({tag, "_keysum"}, d, ksum_a[d] - b_sum[d], sum);
      chk({tag, "_busy"}, d, {31'h0, busy_a[d]}, 32'h1);
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk({tag, "_key"}, d, {8'h0, key_a[d]}, {8'h0, KF[d]});
      chk({tag, "_flags"}, d, {27'h0, busy_a[d], found_a[d], exh_a[d], abort_a[d], sts_a[d]}, 32'h0);
    end
  endtask

  initial begin
    int n;
    logic [31:0] b_dec [3];
    checks = 0; errors = 0;
    reset_n = 0; start = 0; stop = 0;
    for (int d = 0; d < 3; d++) begin tgt[d] = NONE; lat_fix[d] = -1; end
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset_n = 1;

    // directed: hit at key 5; stepped range 1..7 exhausts at 7; top of range exhausts without wrap
    tgt[0] = 25'd5;
    run_search("directed");

    for (int r = 0; r < 6; r++) begin
      tgt[0] = 25'($urandom_range(0, 15));
      tgt[1] = 25'($urandom_range(0, 9));
      tgt[2] = $urandom_range(0, 1) ? 25'hFFFFFE : 25'h5;
      run_search("random");
    end

    // stop while shuffle is in flight: phase finishes, no decrypt follows
    for (int d = 0; d < 3; d++) begin tgt[d] = NONE; lat_fix[d] = 10; end
    pulse_start(1'b0);
    n = 0;
    while (!sss_a[0] && n < 200) begin @(negedge clk); n++; end
    bound("stop_reach_shuf", n, 200);
    for (int d = 0; d < 3; d++) b_dec[d] = ndec_a[d];
    @(negedge clk); stop = 1;
    @(negedge clk); stop = 0;
    repeat (20) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("stop_no_decrypt", d, ndec_a[d], b_dec[d]);
      chk("stop_idle", d, {31'h0, busy_a[d]}, 32'h0);
      chk("stop_aborted", d, {31'h0, abort_a[d]}, 32'h1);
    end

    // start together with stop in IDLE is ignored; a plain start then clears aborted
    pulse_start(1'b1);
    chk("startstop_idle", 0, {29'h0, busy_a}, 32'h0);
    chk("startstop_aborted", 0, {29'h0, abort_a}, 32'h7);
    for (int d = 0; d < 3; d++) lat_fix[d] = -1;
    pulse_start(1'b0);
    chk("restart_busy", 0, {29'h0, busy_a}, 32'h7);
    chk("restart_aborted", 0, {29'h0, abort_a}, 32'h0);

    // asynchronous reset while DUT0 decrypts key 9
    n = 0;
    while (!(dss_a[0] && key_a[0] == 24'd9) && n < 3000) begin @(negedge clk); n++; end
    bound("reach_key9", n, 3000);
    @(negedge clk); reset_n = 0;
    #1;
    check_reset_state("midreset");
    repeat (2) @(negedge clk);
    reset_n = 1;

`ifdef KEY_SEARCH_WATCHDOG_EN
    for (int d = 0; d < 3; d++) lat_fix[d] = 1000000;
    pulse_start(1'b0);
    chk("wd_init_start", 0, {31'h0, ins_a[0]}, 32'h1);
    n = 0;
    while (!pto_a[0] && n < 70000) begin @(negedge clk); n++; end
    chk("wd_latency", 0, n, 65536);
    @(negedge clk);
    chk("wd_pulse_width", 0, {31'h0, pto_a[0]}, 32'h0);
    chk("wd_aborted", 0, {31'h0, abort_a[0]}, 32'h1);
    chk("wd_idle", 0, {31'h0, busy_a[0]}, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
